// File: rtl/s1494_pkg.sv
// Shared types and constants for the s1494 sequential shell and its cone bank.
// Bit positions name the primary-input and next-state vectors seen by the cones.
package s1494_pkg;

   typedef logic [5:0] state_t;
   typedef logic [7:0] pi_t;

   localparam int PI_CLR = 7;
   localparam int NS_V7  = 0;
   localparam int NS_V8  = 1;
   localparam int NS_V9  = 2;
   localparam int NS_V10 = 3;
   localparam int NS_V11 = 4;
   localparam int NS_V12 = 5;

   typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} seq_st_t;

endpackage

// File: rtl/s1494_state_seq.sv
// Sequential shell for the s1494 next-state cones: registers the step inputs and
// present state, waits CONE_LAT cycles for the cones to settle, then commits ns_i.
module s1494_state_seq
   import s1494_pkg::*;
#(
   parameter int CONE_LAT = 2,
   parameter int CNT_W    = 16
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_vec,
   input  logic             ld_valid,
   input  logic [5:0]       ld_state,
   output logic [7:0]       pi_o,
   output logic [5:0]       ps_o,
   input  logic [5:0]       ns_i,
   output logic             out_valid,
   output logic [CNT_W-1:0] step_cnt
);

   localparam logic [3:0] SETTLE_INIT = (CONE_LAT > 0) ? 4'(CONE_LAT - 1) : 4'd0;

   seq_st_t    st, st_nxt;
   logic [3:0] settle_cnt, settle_cnt_nxt;
   logic       accept, commit, load;

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         st         <= IDLE;
         settle_cnt <= 4'd0;
      end else begin
         st         <= st_nxt;
         settle_cnt <= settle_cnt_nxt;
      end
   end

   // Load wins over a step request; SETTLE ignores both request inputs.
   always_comb begin
      st_nxt         = st;
      settle_cnt_nxt = settle_cnt;
      accept         = 1'b0;
      commit         = 1'b0;
      load           = 1'b0;
      case (st)
         IDLE: begin
            if (ld_valid) begin
               load = 1'b1;
            end else if (in_valid) begin
               accept = 1'b1;
               if (CONE_LAT == 0) begin
                  st_nxt = COMMIT;
               end else begin
                  settle_cnt_nxt = SETTLE_INIT;
                  st_nxt         = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (settle_cnt == 4'd0) st_nxt = COMMIT;
            else                    settle_cnt_nxt = settle_cnt - 4'd1;
         end
         COMMIT: begin
            commit = 1'b1;
            st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   assign in_ready = (st == IDLE) && !ld_valid && !RST;

   // ns_i is only looked at in COMMIT, so unsettled cone outputs never reach ps_o.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         pi_o      <= '0;
         ps_o      <= '0;
         out_valid <= 1'b0;
         step_cnt  <= '0;
      end else begin
         out_valid <= commit;
         if (accept) pi_o <= in_vec;
         if (load)        ps_o <= ld_state;
         else if (commit) ps_o <= ns_i;
         if (commit) step_cnt <= step_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_s1494_state_seq.sv
// Bench for s1494_state_seq: a reference cone model feeds ns_i (delayed by CONE_LAT),
// expected committed states go through a scoreboard queue per instance.
module tb_s1494_state_seq;

   localparam int LAT_A = 2;

   logic CK = 1'b0;
   always #5 CK = ~CK;
   logic RST;

   // Instance A: CONE_LAT=2, CNT_W=16
   logic        iv_a, ir_a, lv_a, ov_a;
   logic [7:0]  vec_a, pi_a;
   logic [5:0]  ls_a, ps_a, ns_a;
   logic [15:0] cnt_a;

   // Instance B: CONE_LAT=0, CNT_W=4
   logic        iv_b, ir_b, lv_b, ov_b;
   logic [7:0]  vec_b, pi_b;
   logic [5:0]  ls_b, ps_b, ns_b;
   logic [3:0]  cnt_b;

   s1494_state_seq #(.CONE_LAT(LAT_A), .CNT_W(16)) u_dut_a (
      .CK(CK), .RST(RST), .in_valid(iv_a), .in_ready(ir_a), .in_vec(vec_a),
      .ld_valid(lv_a), .ld_state(ls_a), .pi_o(pi_a), .ps_o(ps_a), .ns_i(ns_a),
      .out_valid(ov_a), .step_cnt(cnt_a));

   s1494_state_seq #(.CONE_LAT(0), .CNT_W(4)) u_dut_b (
      .CK(CK), .RST(RST), .in_valid(iv_b), .in_ready(ir_b), .in_vec(vec_b),
      .ld_valid(lv_b), .ld_state(ls_b), .pi_o(pi_b), .ps_o(ps_b), .ns_i(ns_b),
      .out_valid(ov_b), .step_cnt(cnt_b));

   // Reference cone function: CLR low forces next state to zero.
   function automatic logic [5:0] ref_ns(input logic [7:0] pi, input logic [5:0] ps);
      if (!pi[7]) return 6'h00;
      return (ps + 6'd1) ^ pi[5:0];
   endfunction

   // Cones for A settle over LAT_A cycles; X while the delay line is still changing.
   logic [5:0] d0, d1;
   always @(posedge CK) begin
      d0 <= ref_ns(pi_a, ps_a);
      d1 <= d0;
   end
   assign ns_a = (d0 === d1) ? d1 : 6'bxxxxxx;
   assign ns_b = ref_ns(pi_b, ps_b);

   logic [5:0] exp_q_a[$];
   logic [5:0] exp_q_b[$];
   logic [5:0] model_ps_a, model_ps_b;
   int         model_cnt_a, model_cnt_b;
   int         n_cmp, n_bad;

   task automatic test_reset();
      RST = 1'b1;
      iv_a = 0; lv_a = 0; vec_a = 0; ls_a = 0;
      iv_b = 0; lv_b = 0; vec_b = 0; ls_b = 0;
      repeat (3) @(negedge CK);
      n_cmp++;
      if (ir_a !== 1'b0) begin $display("FAIL rst_ready_during: got %b want 0", ir_a); n_bad++; end
      RST = 1'b0;
      #1;
      n_cmp++;
      if (ps_a !== 6'h00) begin $display("FAIL rst_ps: got %h want 00", ps_a); n_bad++; end
      n_cmp++;
      if (pi_a !== 8'h00) begin $display("FAIL rst_pi: got %h want 00", pi_a); n_bad++; end
      n_cmp++;
      if (cnt_a !== 16'd0) begin $display("FAIL rst_cnt: got %0d want 0", cnt_a); n_bad++; end
      n_cmp++;
      if (ov_a !== 1'b0) begin $display("FAIL rst_out_valid: got %b want 0", ov_a); n_bad++; end
      n_cmp++;
      if (ir_a !== 1'b1) begin $display("FAIL rst_ready_after: got %b want 1", ir_a); n_bad++; end
      n_cmp++;
      if (cnt_b !== 4'd0) begin $display("FAIL rst_cnt_b: got %0d want 0", cnt_b); n_bad++; end
      model_ps_a = 0; model_cnt_a = 0; model_ps_b = 0; model_cnt_b = 0;
   endtask

   // One step on A; SETTLE-window disturbances optional.
   task automatic run_step_a(input logic [7:0] vec, input string nm, input bit disturb);
      int k;
      logic [5:0] e;
      k = 0;
      while (!ir_a && k < 20) begin @(negedge CK); k++; end
      if (!ir_a) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_ready_timeout: in_ready=%b want 1", nm, ir_a);
         return;
      end
      vec_a = vec; iv_a = 1'b1;
      exp_q_a.push_back(ref_ns(vec, model_ps_a));
      @(negedge CK);
      iv_a = 1'b0;
      k = 1;
      if (disturb) begin
         iv_a = 1'b1; vec_a = 8'hFF; lv_a = 1'b1; ls_a = 6'h3F;
         #1;
         n_cmp++;
         if (ir_a !== 1'b0) begin $display("FAIL %s_settle_ready: got %b want 0", nm, ir_a); n_bad++; end
         @(negedge CK); k++;
         iv_a = 1'b0; lv_a = 1'b0;
         n_cmp++;
         if (pi_a !== vec) begin $display("FAIL %s_pi_stable: got %h want %h", nm, pi_a, vec); n_bad++; end
      end
      while (!ov_a && k < 20) begin @(negedge CK); k++; end
      e = exp_q_a.pop_front();
      n_cmp++;
      if (!ov_a) begin
         $display("FAIL %s_commit_timeout: out_valid=%b want 1", nm, ov_a); n_bad++;
         return;
      end
      n_cmp++;
      if (k - 1 !== LAT_A + 1) begin
         $display("FAIL %s_latency: got %0d cycles want %0d", nm, k - 1, LAT_A + 1); n_bad++;
      end
      n_cmp++;
      if (ps_a !== e) begin $display("FAIL %s_ps: got %h want %h", nm, ps_a, e); n_bad++; end
      model_ps_a = e;
      model_cnt_a++;
      n_cmp++;
      if (cnt_a !== 16'(model_cnt_a)) begin
         $display("FAIL %s_cnt: got %0d want %0d", nm, cnt_a, model_cnt_a); n_bad++;
      end
      @(negedge CK);
      n_cmp++;
      if (ov_a !== 1'b0) begin $display("FAIL %s_pulse_width: got %b want 0", nm, ov_a); n_bad++; end
   endtask

   task automatic test_basic_step();
      run_step_a(8'h80, "step80", 1'b0);
   endtask

   task automatic test_ld_priority();
      bit seen;
      lv_a = 1'b1; ls_a = 6'h2A; iv_a = 1'b1; vec_a = 8'h80;
      #1;
      n_cmp++;
      if (ir_a !== 1'b0) begin $display("FAIL ld_ready: got %b want 0", ir_a); n_bad++; end
      @(negedge CK);
      lv_a = 1'b0; iv_a = 1'b0;
      n_cmp++;
      if (ps_a !== 6'h2A) begin $display("FAIL ld_ps: got %h want 2a", ps_a); n_bad++; end
      seen = 1'b0;
      repeat (6) begin
         if (ov_a) seen = 1'b1;
         @(negedge CK);
      end
      n_cmp++;
      if (seen) begin $display("FAIL ld_no_step: out_valid seen want none"); n_bad++; end
      n_cmp++;
      if (cnt_a !== 16'(model_cnt_a)) begin
         $display("FAIL ld_cnt: got %0d want %0d", cnt_a, model_cnt_a); n_bad++;
      end
      model_ps_a = 6'h2A;
   endtask

   task automatic test_clr_low();
      bit seen;
      run_step_a(8'h15, "clr_low", 1'b1);
      seen = 1'b0;
      repeat (6) begin
         if (ov_a) seen = 1'b1;
         @(negedge CK);
      end
      n_cmp++;
      if (seen) begin $display("FAIL clr_low_extra_step: out_valid seen want none"); n_bad++; end
      n_cmp++;
      if (ps_a !== 6'h00) begin $display("FAIL clr_low_ps_hold: got %h want 00", ps_a); n_bad++; end
   endtask

   task automatic test_reset_mid();
      bit seen;
      vec_a = 8'h81; iv_a = 1'b1;
      @(negedge CK);
      iv_a = 1'b0;
      @(negedge CK);
      RST = 1'b1;
      #1;
      n_cmp++;
      if (ps_a !== 6'h00) begin $display("FAIL midrst_ps: got %h want 00", ps_a); n_bad++; end
      n_cmp++;
      if (pi_a !== 8'h00) begin $display("FAIL midrst_pi: got %h want 00", pi_a); n_bad++; end
      n_cmp++;
      if (cnt_a !== 16'd0) begin $display("FAIL midrst_cnt: got %0d want 0", cnt_a); n_bad++; end
      n_cmp++;
      if (ir_a !== 1'b0) begin $display("FAIL midrst_ready: got %b want 0", ir_a); n_bad++; end
      seen = 1'b0;
      repeat (2) begin
         @(negedge CK);
         if (ov_a) seen = 1'b1;
      end
      RST = 1'b0;
      #1;
      n_cmp++;
      if (ir_a !== 1'b1) begin $display("FAIL midrst_idle: in_ready=%b want 1", ir_a); n_bad++; end
      repeat (5) begin
         @(negedge CK);
         if (ov_a) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin $display("FAIL midrst_no_commit: out_valid seen want none"); n_bad++; end
      model_ps_a = 0; model_cnt_a = 0; model_ps_b = 0; model_cnt_b = 0;
      run_step_a(8'h83, "post_rst", 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      logic [5:0] e;
      for (int i = 0; i < 17; i++) begin
         n_cmp++;
         if (ir_b !== 1'b1) begin $display("FAIL b2b_ready[%0d]: got %b want 1", i, ir_b); n_bad++; end
         v = {1'b1, 7'($urandom)};
         vec_b = v; iv_b = 1'b1;
         exp_q_b.push_back(ref_ns(v, model_ps_b));
         @(negedge CK);
         iv_b = 1'b0;
         @(negedge CK);
         n_cmp++;
         if (ov_b !== 1'b1) begin $display("FAIL b2b_valid[%0d]: got %b want 1", i, ov_b); n_bad++; end
         e = exp_q_b.pop_front();
         model_ps_b = e;
         model_cnt_b = (model_cnt_b + 1) % 16;
         n_cmp++;
         if (ps_b !== e) begin $display("FAIL b2b_ps[%0d]: got %h want %h", i, ps_b, e); n_bad++; end
         n_cmp++;
         if (cnt_b !== 4'(model_cnt_b)) begin
            $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, cnt_b, model_cnt_b); n_bad++;
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      test_reset();
      test_basic_step();
      test_ld_priority();
      test_clr_low();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
